clk_wiz_vio: RTL and testbench

//   Synthesizable stand-in for the board clock-manager + virtual-I/O pair used by m_main.
//   - Divides w_clk into a slower processor clock w_clk2.
//   - Reports lock after a fixed number of w_clk2 periods.
//   - Samples the processor's 32-bit debug word once per w_clk2 period into a readable

---
 rtl/clk_wiz_vio_pkg.sv | 34 +++
 rtl/clk_wiz_vio_probe.sv | 64 ++++++
 rtl/clk_wiz_vio.sv | 114 +++++++++++
 tb/tb_clk_wiz_vio.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_wiz_vio_pkg.sv
// clk_wiz_vio_pkg
//   Shared definitions for the clock-manager / virtual-I/O stand-in:
//   - default probe and change-counter widths
//   - the qualifier bundle handed from the divider/lock logic to the probe
//   - a saturating increment used by the change counter
package clk_wiz_vio_pkg;

    localparam int PROBE_W_DEF = 32;
    localparam int CNT_W_DEF   = 16;

    // Conditions under which the probe may capture. The sub-module combines
    // them itself so that the top only has to describe what happened this edge.
    typedef struct packed {
        logic rise;    // w_clk2 goes 0->1 on this w_clk edge
        logic locked;  // lock already established before this edge
        logic freeze;  // user hold request
    } probe_qual_t;

    // Increment v, but stick at the all-ones value of a w-bit counter (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] all_ones;
        if (w >= 32) begin
            all_ones = 32'hFFFF_FFFF;
        end else begin
            all_ones = (32'd1 << w) - 32'd1;
        end
        if (v >= all_ones) begin
            sat_inc = all_ones;
        end else begin
            sat_inc = v + 32'd1;
        end
    endfunction

endpackage

// File: rtl/clk_wiz_vio_probe.sv
// vio_probe
//   Capture register for the processor debug word. On a qualified rise event
//   (rise && locked && !freeze) the input word is stored, the valid flag set,
//   and the change counter bumped when the new word differs from the held one.
//   The very first capture after reset never counts as a change.
// Ports
//   clk, rst     clock and synchronous active-high reset
//   qual         rise / locked / freeze qualifiers from the top
//   probe_in     word to observe
//   probe_out    last captured word
//   probe_valid  at least one capture since reset
//   probe_chg    saturating count of captured changes
module vio_probe
    import clk_wiz_vio_pkg::*;
#(
    parameter int PROBE_W = PROBE_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  probe_qual_t        qual,
    input  logic [PROBE_W-1:0] probe_in,
    output logic [PROBE_W-1:0] probe_out,
    output logic               probe_valid,
    output logic [CNT_W-1:0]   probe_chg
);

    logic [PROBE_W-1:0] data_q,  data_d;
    logic               valid_q, valid_d;
    logic [CNT_W-1:0]   chg_q,   chg_d;
    logic               capture;

    always_comb begin
        capture = qual.rise & qual.locked & ~qual.freeze;
        data_d  = data_q;
        valid_d = valid_q;
        chg_d   = chg_q;
        if (capture) begin
            data_d  = probe_in;
            valid_d = 1'b1;
            // Only compare against a value that was actually captured.
            if (valid_q && (probe_in != data_q)) begin
                chg_d = CNT_W'(sat_inc(32'(chg_q), CNT_W));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            chg_q   <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            chg_q   <= chg_d;
        end
    end

    assign probe_out   = data_q;
    assign probe_valid = valid_q;
    assign probe_chg   = chg_q;

endmodule

// File: rtl/clk_wiz_vio.sv
// clk_wiz_vio
//   Synthesizable stand-in for the board clock manager plus virtual I/O.
//   - Divides w_clk by 2*DIV_HALF into a registered w_clk2.
//   - Asserts w_locked (sticky) on the LOCK_CYCLES-th rising edge of w_clk2.
//   - Samples w_probe_in0 once per w_clk2 period once locked (see vio_probe).
//   All state lives in the w_clk domain; w_clk2 is a data output, never used
//   as a clock inside this block.
// Ports
//   w_clk          sole clock
//   w_rst          synchronous active-high reset
//   w_clk2         divided clock output
//   w_locked       lock indication, cleared only by reset
//   w_probe_in0    debug word to observe
//   w_freeze       hold captured probe and counter
//   w_probe_out0   last captured probe value
//   w_probe_valid  probe holds at least one capture
//   w_probe_chg    saturating count of captured changes
module clk_wiz_vio
    import clk_wiz_vio_pkg::*;
#(
    parameter int DIV_HALF    = 1,
    parameter int LOCK_CYCLES = 16,
    parameter int PROBE_W     = PROBE_W_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic               w_clk,
    input  logic               w_rst,
    output logic               w_clk2,
    output logic               w_locked,
    input  logic [PROBE_W-1:0] w_probe_in0,
    input  logic               w_freeze,
    output logic [PROBE_W-1:0] w_probe_out0,
    output logic               w_probe_valid,
    output logic [CNT_W-1:0]   w_probe_chg
);

    localparam int DIV_W  = (DIV_HALF > 1)    ? $clog2(DIV_HALF)    : 1;
    localparam int LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [DIV_W-1:0]  div_cnt_q,  div_cnt_d;
    logic              clk2_q,     clk2_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q,   locked_d;
    logic              terminal;
    logic              rise;
    probe_qual_t       qual;

    // Divider: toggle w_clk2 every DIV_HALF input cycles.
    always_comb begin
        terminal = (div_cnt_q == DIV_W'(DIV_HALF - 1));
        // Rise event: the toggle that takes w_clk2 from 0 to 1.
        rise     = terminal & ~clk2_q;
        if (terminal) begin
            div_cnt_d = '0;
            clk2_d    = ~clk2_q;
        end else begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
            clk2_d    = clk2_q;
        end
    end

    // Lock: count rise events; on the last one assert lock on the same edge
    // and leave the counter where it is.
    always_comb begin
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        if (rise && !locked_q) begin
            if (lock_cnt_q == LOCK_W'(LOCK_CYCLES - 1)) begin
                locked_d = 1'b1;
            end else begin
                lock_cnt_d = lock_cnt_q + LOCK_W'(1);
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            div_cnt_q  <= '0;
            clk2_q     <= 1'b0;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            div_cnt_q  <= div_cnt_d;
            clk2_q     <= clk2_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    // The registered lock flag is used, so the rise that completes lock does
    // not also capture; capture begins on the following rise.
    always_comb begin
        qual.rise   = rise;
        qual.locked = locked_q;
        qual.freeze = w_freeze;
    end

    vio_probe #(
        .PROBE_W (PROBE_W),
        .CNT_W   (CNT_W)
    ) u_probe (
        .clk         (w_clk),
        .rst         (w_rst),
        .qual        (qual),
        .probe_in    (w_probe_in0),
        .probe_out   (w_probe_out0),
        .probe_valid (w_probe_valid),
        .probe_chg   (w_probe_chg)
    );

    assign w_clk2   = clk2_q;
    assign w_locked = locked_q;

endmodule

// File: tb/tb_clk_wiz_vio.sv
// Bench for clk_wiz_vio. Two instances share clock, reset, freeze and probe:
//   u0: DIV_HALF=1, LOCK_CYCLES=16, 32-bit probe, 16-bit counter
//   u1: DIV_HALF=2, LOCK_CYCLES=4,  8-bit probe,  2-bit counter (saturates fast)
// The reference model tracks only the number of edges since reset release and
// derives w_clk2, lock and capture points from that count arithmetically.
module tb_clk_wiz_vio;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic [31:0] probe_in;
    logic [7:0]  probe_in8;

    logic        clk2_0, locked_0, valid_0;
    logic [31:0] out_0;
    logic [15:0] chg_0;
    logic        clk2_1, locked_1, valid_1;
    logic [7:0]  out_1;
    logic [1:0]  chg_1;

    int n_checks = 0;
    int n_fail   = 0;

    assign probe_in8 = probe_in[7:0];

    clk_wiz_vio #(.DIV_HALF(1), .LOCK_CYCLES(16), .PROBE_W(32), .CNT_W(16)) u0 (
        .w_clk         (clk),
        .w_rst         (rst),
        .w_clk2        (clk2_0),
        .w_locked      (locked_0),
        .w_probe_in0   (probe_in),
        .w_freeze      (freeze),
        .w_probe_out0  (out_0),
        .w_probe_valid (valid_0),
        .w_probe_chg   (chg_0)
    );

    clk_wiz_vio #(.DIV_HALF(2), .LOCK_CYCLES(4), .PROBE_W(8), .CNT_W(2)) u1 (
        .w_clk         (clk),
        .w_rst         (rst),
        .w_clk2        (clk2_1),
        .w_locked      (locked_1),
        .w_probe_in0   (probe_in8),
        .w_freeze      (freeze),
        .w_probe_out0  (out_1),
        .w_probe_valid (valid_1),
        .w_probe_chg   (chg_1)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int          m_n[2];
    logic [31:0] m_out[2];
    logic        m_valid[2];
    int          m_chg[2];

    function automatic int p_div(int k);  return (k == 0) ? 1 : 2;     endfunction
    function automatic int p_lock(int k); return (k == 0) ? 16 : 4;    endfunction
    function automatic int p_cmax(int k); return (k == 0) ? 65535 : 3; endfunction
    function automatic logic [31:0] p_mask(int k);
        return (k == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    endfunction

    // w_clk2 level after n edges: it toggles every DIV_HALF edges from 0.
    function automatic logic exp_clk2(int k, int n);
        return ((n / p_div(k)) % 2) == 1;
    endfunction
    // Rising edges of w_clk2 seen after n edges.
    function automatic int rises_after(int k, int n);
        return ((n / p_div(k)) + 1) / 2;
    endfunction
    function automatic logic exp_locked(int k, int n);
        return rises_after(k, n) >= p_lock(k);
    endfunction

    task automatic model_edge(int k);
        int          nn;
        logic        rise_now;
        logic [31:0] v;
        if (rst) begin
            m_n[k]     = 0;
            m_out[k]   = '0;
            m_valid[k] = 1'b0;
            m_chg[k]   = 0;
        end else begin
            nn       = m_n[k] + 1;
            rise_now = rises_after(k, nn) > rises_after(k, m_n[k]);
            if (rise_now && exp_locked(k, m_n[k]) && !freeze) begin
                v = probe_in & p_mask(k);
                if (m_valid[k] && (v != m_out[k]) && (m_chg[k] < p_cmax(k))) m_chg[k]++;
                m_out[k]   = v;
                m_valid[k] = 1'b1;
            end
            m_n[k] = nn;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("u0_clk2",   32'(clk2_0),   32'(exp_clk2(0, m_n[0])));
        chk("u0_locked", 32'(locked_0), 32'(exp_locked(0, m_n[0])));
        chk("u0_out",    out_0,         m_out[0]);
        chk("u0_valid",  32'(valid_0),  32'(m_valid[0]));
        chk("u0_chg",    32'(chg_0),    32'(m_chg[0]));
        chk("u1_clk2",   32'(clk2_1),   32'(exp_clk2(1, m_n[1])));
        chk("u1_locked", 32'(locked_1), 32'(exp_locked(1, m_n[1])));
        chk("u1_out",    32'(out_1),    m_out[1]);
        chk("u1_valid",  32'(valid_1),  32'(m_valid[1]));
        chk("u1_chg",    32'(chg_1),    32'(m_chg[1]));
    endtask

    // One w_clk edge: advance the model with the inputs the DUT will sample,
    // then compare #1 after the edge.
    task automatic tick();
        model_edge(0);
        model_edge(1);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_clk2"},   32'(clk2_0),   32'd0);
        chk({tag, "_locked"}, 32'(locked_0), 32'd0);
        chk({tag, "_out"},    out_0,         32'd0);
        chk({tag, "_valid"},  32'(valid_0),  32'd0);
        chk({tag, "_chg"},    32'(chg_0),    32'd0);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic        freeze;
        logic [31:0] din;
        logic [31:0] exp_out;
        logic        exp_valid;
        logic [15:0] exp_chg;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [5:0] u1_pat;
        int         e;

        vecs[0] = '{1'b0, 32'h1234_5678, 32'h1234_5678, 1'b1, 16'd0};
        vecs[1] = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 16'd1};
        vecs[2] = '{1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 16'd1};
        for (int i = 3; i < 8; i++) vecs[i] = '{1'b1, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b1, 16'd1};
        vecs[8] = '{1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1, 16'd2};

        rst      = 1'b1;
        freeze   = 1'b0;
        probe_in = 32'h0;

        // Reset held for three edges.
        repeat (3) tick();
        check_all_zero("reset");

        // Release; u1 (DIV_HALF=2) must rise at edge 2 and fall at edge 4.
        rst    = 1'b0;
        u1_pat = 6'b100110;
        e      = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            e++;
            chk("u1_div_pattern", 32'(clk2_1), 32'(u1_pat[i]));
            if (e == 1) chk("u0_first_rise", 32'(clk2_0), 32'd1);
        end

        // u0 lock lands on edge 31, not before.
        while (e < 30) begin
            tick();
            e++;
        end
        chk("u0_unlocked_at_30", 32'(locked_0), 32'd0);
        tick();
        e++;
        chk("u0_locked_at_31", 32'(locked_0), 32'd1);
        chk("u0_no_capture_on_lock_rise", 32'(valid_0), 32'd0);

        // One w_clk2 period (2 edges) per row, ending right after a rise.
        for (int i = 0; i < 9; i++) begin
            freeze   = vecs[i].freeze;
            probe_in = vecs[i].din;
            tick();
            tick();
            chk("vec_out",   out_0,            vecs[i].exp_out);
            chk("vec_valid", 32'(valid_0),     32'(vecs[i].exp_valid));
            chk("vec_chg",   32'(chg_0),       32'(vecs[i].exp_chg));
        end

        // Randomized traffic with occasional freeze; small value pool so
        // repeats and changes both occur, and u1's 2-bit counter saturates.
        for (int i = 0; i < 400; i++) begin
            probe_in = 32'h1111_1111 * $urandom_range(0, 3);
            freeze   = ($urandom_range(0, 4) == 0);
            tick();
        end
        chk("u1_saturated", 32'(chg_1), 32'd3);

        // Reset pulse while locked, then relock takes 31 edges again.
        freeze = 1'b0;
        rst    = 1'b1;
        tick();
        check_all_zero("repulse");
        rst = 1'b0;
        repeat (30) tick();
        chk("relock_not_at_30", 32'(locked_0), 32'd0);
        tick();
        chk("relock_at_31", 32'(locked_0), 32'd1);

        for (int i = 0; i < 60; i++) begin
            probe_in = $urandom;
            freeze   = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
